// File: rtl/multi_channel_interval_timer_if.sv
// Bus bundle for the multi-channel interval timer: start/stop markers in,
// captured intervals and status out.
interface multi_channel_interval_timer_if #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 2
);
  logic                   start;
  logic [N_CH-1:0]        stop;
  logic [N_CH*WIDTH-1:0]  count_out;
  logic [N_CH-1:0]        captured;
  logic                   busy;
  logic                   done;
  logic                   overflow;

  modport master (
    output start, stop,
    input  count_out, captured, busy, done, overflow
  );

  modport slave (
    input  start, stop,
    output count_out, captured, busy, done, overflow
  );
endinterface

// File: rtl/multi_channel_interval_timer.sv
// Measures clk cycles from a start rising edge to the first rising edge on each
// stop channel, with saturation/overflow detection and optional retrigger.
module multi_channel_interval_timer #(
  parameter int WIDTH     = 8,
  parameter int N_CH      = 2,
  parameter bit RETRIGGER = 1'b0
) (
  input logic                          clk,
  input logic                          reset,
  multi_channel_interval_timer_if.slave bus
);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state, state_nx;
  logic                   start_d;
  logic [N_CH-1:0]        stop_d;
  logic                   start_edge;
  logic [N_CH-1:0]        stop_edge;
  logic                   restart;
  logic [WIDTH-1:0]       counter, counter_nx;
  logic [N_CH*WIDTH-1:0]  count_nx;
  logic [N_CH-1:0]        captured_nx;
  logic                   overflow_nx;

  assign start_edge = bus.start & ~start_d;
  assign stop_edge  = bus.stop & ~stop_d;
  assign restart    = start_edge && ((state != RUN) || RETRIGGER);

  always_comb begin
    state_nx    = state;
    counter_nx  = counter;
    count_nx    = bus.count_out;
    captured_nx = bus.captured;
    overflow_nx = bus.overflow;
    if (restart) begin
      // A stop edge coincident with the start edge is a zero-length interval.
      counter_nx  = CNT_ONE;
      count_nx    = '0;
      captured_nx = stop_edge;
      overflow_nx = 1'b0;
      state_nx    = RUN;
    end else if (state == RUN) begin
      if (counter == CNT_MAX) begin
        // Only reachable with channels still open; they all report all-ones.
        state_nx    = DONE;
        overflow_nx = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
          if (!bus.captured[i]) begin
            count_nx[i*WIDTH +: WIDTH] = CNT_MAX;
            captured_nx[i]             = stop_edge[i];
          end
        end
      end else begin
        counter_nx = counter + CNT_ONE;
        for (int i = 0; i < N_CH; i++) begin
          if (stop_edge[i] && !bus.captured[i]) begin
            count_nx[i*WIDTH +: WIDTH] = counter;
            captured_nx[i]             = 1'b1;
          end
        end
        if (&captured_nx) state_nx = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    // Edge registers track the inputs through reset so a held line gives no edge.
    start_d <= bus.start;
    stop_d  <= bus.stop;
    if (reset) begin
      state         <= IDLE;
      counter       <= '0;
      bus.count_out <= '0;
      bus.captured  <= '0;
      bus.overflow  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      state         <= state_nx;
      counter       <= counter_nx;
      bus.count_out <= count_nx;
      bus.captured  <= captured_nx;
      bus.overflow  <= overflow_nx;
      bus.busy      <= (state_nx == RUN);
      bus.done      <= (state_nx == DONE);
    end
  end
endmodule

// File: tb/tb_multi_channel_interval_timer.sv
// Directed bench for multi_channel_interval_timer: scoreboard queues per instance,
// popped by monitors on each rising edge of done.
module tb_multi_channel_interval_timer;
  logic clk;
  logic reset;

  typedef struct {
    logic [31:0] cnt;
    logic [3:0]  cap;
    logic        ovf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int n_checks = 0;
  int n_pass   = 0;

  multi_channel_interval_timer_if #(.WIDTH(8), .N_CH(2)) bus0 ();
  multi_channel_interval_timer_if #(.WIDTH(8), .N_CH(2)) bus1 ();
  multi_channel_interval_timer_if #(.WIDTH(4), .N_CH(4)) bus2 ();

  multi_channel_interval_timer #(.WIDTH(8), .N_CH(2), .RETRIGGER(1'b0)) u0 (
    .clk(clk), .reset(reset), .bus(bus0));
  multi_channel_interval_timer #(.WIDTH(8), .N_CH(2), .RETRIGGER(1'b1)) u1 (
    .clk(clk), .reset(reset), .bus(bus1));
  multi_channel_interval_timer #(.WIDTH(4), .N_CH(4), .RETRIGGER(1'b0)) u2 (
    .clk(clk), .reset(reset), .bus(bus2));

  initial clk = 1'b0;
  always #4 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return bus0.done;
      1:       return bus1.done;
      default: return bus2.done;
    endcase
  endfunction

  task automatic wait_done(input int sel, input int max);
    int k = 0;
    while (!done_of(sel) && k < max) begin
      tick(1);
      k++;
    end
    if (!done_of(sel)) check($sformatf("timeout_done_u%0d", sel), 32'd0, 32'd1);
  endtask

  function automatic exp_t mk(input logic [31:0] cnt, input logic [3:0] cap, input logic ovf);
    exp_t e;
    e.cnt = cnt;
    e.cap = cap;
    e.ovf = ovf;
    return e;
  endfunction

  logic done0_q, done1_q, done2_q;

  always @(negedge clk) begin
    exp_t e;
    if (bus0.done && !done0_q) begin
      if (q0.size() == 0) check("u0_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        check("u0_count_out", 32'(bus0.count_out), e.cnt);
        check("u0_captured", 32'(bus0.captured), 32'(e.cap));
        check("u0_overflow", 32'(bus0.overflow), 32'(e.ovf));
      end
    end
    done0_q <= bus0.done;
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus1.done && !done1_q) begin
      if (q1.size() == 0) check("u1_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        check("u1_count_out", 32'(bus1.count_out), e.cnt);
        check("u1_captured", 32'(bus1.captured), 32'(e.cap));
        check("u1_overflow", 32'(bus1.overflow), 32'(e.ovf));
      end
    end
    done1_q <= bus1.done;
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus2.done && !done2_q) begin
      if (q2.size() == 0) check("u2_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q2.pop_front();
        check("u2_count_out", 32'(bus2.count_out), e.cnt);
        check("u2_captured", 32'(bus2.captured), 32'(e.cap));
        check("u2_overflow", 32'(bus2.overflow), 32'(e.ovf));
      end
    end
    done2_q <= bus2.done;
  end

  initial begin
    done0_q = 1'b0; done1_q = 1'b0; done2_q = 1'b0;
    reset = 1'b1;
    bus0.start = 1'b0; bus0.stop = '0;
    bus1.start = 1'b0; bus1.stop = '0;
    bus2.start = 1'b0; bus2.stop = '0;
    tick(3);
    reset = 1'b0;
    tick(1);

    // Reset state
    check("rst_count_out", 32'(bus0.count_out), 32'd0);
    check("rst_captured", 32'(bus0.captured), 32'd0);
    check("rst_busy", 32'(bus0.busy), 32'd0);
    check("rst_done", 32'(bus0.done), 32'd0);
    check("rst_overflow", 32'(bus0.overflow), 32'd0);
    check("rst_u2_count_out", 32'(bus2.count_out), 32'd0);

    // Test 1: stop[0] 5 clks, stop[1] 12 clks after start
    q0.push_back(mk(32'h0C05, 4'b0011, 1'b0));
    bus0.start = 1'b1; tick(1);
    bus0.start = 1'b0; tick(4);
    bus0.stop[0] = 1'b1; tick(7);
    bus0.stop[1] = 1'b1;
    wait_done(0, 20);
    bus0.stop = '0; tick(2);

    // Test 2: start and stop[0] together; repeated stop[0] ignored
    q0.push_back(mk(32'h0300, 4'b0011, 1'b0));
    bus0.start = 1'b1; bus0.stop[0] = 1'b1; tick(1);
    bus0.start = 1'b0; bus0.stop[0] = 1'b0; tick(1);
    bus0.stop[0] = 1'b1; tick(1);
    bus0.stop[1] = 1'b1;
    wait_done(0, 20);
    bus0.stop = '0; tick(2);

    // Test 3: stop[1] never arrives, counter saturates
    q0.push_back(mk(32'hFF05, 4'b0001, 1'b1));
    bus0.start = 1'b1; tick(1);
    bus0.start = 1'b0; tick(4);
    bus0.stop[0] = 1'b1;
    wait_done(0, 300);
    check("sat_busy", 32'(bus0.busy), 32'd0);
    check("sat_done", 32'(bus0.done), 32'd1);
    bus0.stop = '0; tick(2);

    // Test 4: second start 4 clks in; RETRIGGER=0 on u0, RETRIGGER=1 on u1
    q0.push_back(mk(32'h0B0A, 4'b0011, 1'b0));
    q1.push_back(mk(32'h0706, 4'b0011, 1'b0));
    bus0.start = 1'b1; bus1.start = 1'b1; tick(1);
    bus0.start = 1'b0; bus1.start = 1'b0; tick(3);
    bus0.start = 1'b1; bus1.start = 1'b1; tick(1);
    bus0.start = 1'b0; bus1.start = 1'b0; tick(5);
    bus0.stop[0] = 1'b1; bus1.stop[0] = 1'b1; tick(1);
    bus0.stop[1] = 1'b1; bus1.stop[1] = 1'b1;
    wait_done(0, 20);
    wait_done(1, 20);
    bus0.stop = '0; bus1.stop = '0; tick(2);

    // Test 5: reset mid-run with start held high
    bus0.start = 1'b1; tick(3);
    reset = 1'b1; tick(2);
    reset = 1'b0; tick(3);
    check("abort_count_out", 32'(bus0.count_out), 32'd0);
    check("abort_captured", 32'(bus0.captured), 32'd0);
    check("abort_busy", 32'(bus0.busy), 32'd0);
    check("abort_done", 32'(bus0.done), 32'd0);
    check("abort_overflow", 32'(bus0.overflow), 32'd0);
    q0.push_back(mk(32'h0402, 4'b0011, 1'b0));
    bus0.start = 1'b0; tick(1);
    bus0.start = 1'b1; tick(1);
    check("fresh_busy", 32'(bus0.busy), 32'd1);
    bus0.start = 1'b0; tick(1);
    bus0.stop[0] = 1'b1; tick(2);
    bus0.stop[1] = 1'b1;
    wait_done(0, 20);
    bus0.stop = '0; tick(2);

    // Test 6: WIDTH=4, N_CH=4; simultaneous stops, then back-to-back rearm
    q2.push_back(mk(32'h7777, 4'b1111, 1'b0));
    bus2.start = 1'b1; tick(1);
    bus2.start = 1'b0; tick(6);
    bus2.stop = 4'hF; tick(1);
    check("u2_done_next", 32'(bus2.done), 32'd1);
    q2.push_back(mk(32'h4343, 4'b1111, 1'b0));
    bus2.start = 1'b1; bus2.stop = '0; tick(1);
    check("rearm_captured", 32'(bus2.captured), 32'd0);
    check("rearm_busy", 32'(bus2.busy), 32'd1);
    bus2.start = 1'b0; tick(2);
    bus2.stop = 4'b0101; tick(1);
    bus2.stop = 4'b1111;
    wait_done(2, 20);
    bus2.stop = '0; tick(3);

    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q2_drained", 32'(q2.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
